// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit:
// FSM states, instruction field layout, HCT opcode and FIFO sizing.
package instr_fetch_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 2;

    // Instruction field bit positions
    localparam int MEM_EN_BIT  = 31;
    localparam int MEM_CTRL_HI = 30;
    localparam int MEM_CTRL_LO = 29;
    localparam int ULA_OP_HI   = 28;
    localparam int ULA_OP_LO   = 25;
    localparam int IMM_HI      = 24;
    localparam int IMM_LO      = 0;

    // HCT (halt) opcode
    localparam logic       HCT_MEM_EN   = 1'b1;
    localparam logic [1:0] HCT_MEM_CTRL = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP,
        ST_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    function automatic logic is_hct(input logic [31:0] w);
        return (w[MEM_EN_BIT] == HCT_MEM_EN) &&
               (w[MEM_CTRL_HI:MEM_CTRL_LO] == HCT_MEM_CTRL);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, word} buffer between fetch and decode.
// Ports: clk, rst_n (sync), push/wdata, pop, flush, head, count.
module fetch_fifo
    import instr_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     wdata,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [FIFO_DEPTH];
    fetch_entry_t     mem_d [FIFO_DEPTH];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push &&
                   ((count_q != CNT_W'(FIFO_DEPTH)) || do_pop);
        if (flush) begin
            // flush wins over any same-cycle push or pop
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requester
// feeding a 2-entry buffer, with flush/redirect and HCT halt.
// Ports: _clock, _reset_n (sync, active-low), start, imem_* (memory),
// instr_* (decode handshake), flush/flush_pc, halted, busy.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic        _clock,
    input  logic        _reset_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        halted,
    output logic        busy
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      addr_sel;
    logic             push, pop;
    logic             outstanding;
    fetch_entry_t     head;
    logic [CNT_W-1:0] count;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        imem_req    = 1'b0;
        addr_sel    = pc_q;
        push        = 1'b0;
        outstanding = (state_q == ST_WAIT) || (state_q == ST_DROP);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // no new request in a flush cycle: nothing may be
                // left in flight toward the redirected stream
                if (!flush && (count != CNT_W'(FIFO_DEPTH))) begin
                    imem_req   = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                imem_req = 1'b1;
                addr_sel = req_addr_q;
                if (imem_ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd1;
                    state_d = is_hct(imem_rdata) ? ST_HALT : ST_REQ;
                end
            end
            ST_DROP: begin
                imem_req = 1'b1;
                addr_sel = req_addr_q;
                if (imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            push    = 1'b0;
            pc_d    = flush_pc;
            state_d = (outstanding && !imem_ack) ? ST_DROP : ST_REQ;
        end
    end

    always_ff @(posedge _clock) begin
        if (!_reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign pop = instr_valid && instr_ready && !flush;

    fetch_fifo u_fifo (
        .clk   (_clock),
        .rst_n (_reset_n),
        .push  (push),
        .wdata ('{pc: pc_q, word: imem_rdata}),
        .pop   (pop),
        .flush (flush),
        .head  (head),
        .count (count)
    );

    assign imem_addr   = imem_req ? addr_sel : '0;
    assign instr_valid = (count != '0);
    assign instr       = head.word;
    assign instr_pc    = head.pc;
    assign halted      = (state_q == ST_HALT) && (count == '0);
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: start, backpressure, HCT halt,
// flush/drop, pc wrap and reset during an outstanding request.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halted;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch dut (
        ._clock      (clk),
        ._reset_n    (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .halted      (halted),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"},    32'(imem_req),    32'd0);
        chk({tag, ".addr"},   imem_addr,        32'd0);
        chk({tag, ".valid"},  32'(instr_valid), 32'd0);
        chk({tag, ".instr"},  instr,            32'd0);
        chk({tag, ".pc"},     instr_pc,         32'd0);
        chk({tag, ".halted"}, 32'(halted),      32'd0);
        chk({tag, ".busy"},   32'(busy),        32'd0);
    endtask

    task automatic do_reset();
        start       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        flush       = 1'b0;
        flush_pc    = '0;
        rst_n       = 1'b0;
        nxt();
        nxt();
        neg();
        chk_all_zero("reset");
        nxt();
        rst_n = 1'b1;
    endtask

    logic [31:0] wc [4];

    initial begin
        wc[0] = 32'h1;
        wc[1] = 32'h2;
        wc[2] = 32'h3;
        wc[3] = 32'hA000_0000;

        // A: ack every cycle, ready=1
        do_reset();
        start = 1'b1;
        neg();
        chk("A.idle_busy", 32'(busy), 32'd0);
        nxt();
        start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1;
        instr_ready = 1'b1;
        neg();
        chk("A.req0", 32'(imem_req), 32'd1);
        chk("A.addr0", imem_addr, 32'd0);
        chk("A.busy", 32'(busy), 32'd1);
        nxt();
        neg();
        chk("A.wait_addr0", imem_addr, 32'd0);
        chk("A.valid_early", 32'(instr_valid), 32'd0);
        nxt();
        imem_rdata = 32'h2;
        neg();
        chk("A.valid_first", 32'(instr_valid), 32'd1);
        chk("A.pc0", instr_pc, 32'd0);
        chk("A.instr0", instr, 32'h1);
        chk("A.addr1", imem_addr, 32'd1);
        nxt();
        neg();
        chk("A.valid_gap", 32'(instr_valid), 32'd0);
        nxt();
        imem_ack = 1'b0;
        neg();
        chk("A.pc1", instr_pc, 32'd1);
        chk("A.instr1", instr, 32'h2);
        nxt();

        // B: backpressure
        do_reset();
        start = 1'b1;
        nxt();
        start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h11;
        nxt();
        nxt();
        imem_rdata = 32'h22;
        neg();
        chk("B.addr1", imem_addr, 32'd1);
        nxt();
        nxt();
        neg();
        chk("B.full_req", 32'(imem_req), 32'd0);
        chk("B.full_pc", instr_pc, 32'd0);
        chk("B.full_instr", instr, 32'h11);
        nxt();
        instr_ready = 1'b1;
        neg();
        chk("B.full_req2", 32'(imem_req), 32'd0);
        nxt();
        instr_ready = 1'b0; imem_ack = 1'b0;
        neg();
        chk("B.refill_req", 32'(imem_req), 32'd1);
        chk("B.refill_addr", imem_addr, 32'd2);
        chk("B.head_pc", instr_pc, 32'd1);
        chk("B.head_instr", instr, 32'h22);
        nxt();

        // C: HCT at addr 3
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        nxt();
        start = 1'b0;
        imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            imem_rdata = wc[k];
            neg();
            chk("C.req", 32'(imem_req), 32'd1);
            chk("C.addr", imem_addr, 32'(k));
            if (k > 0) begin
                chk("C.valid", 32'(instr_valid), 32'd1);
                chk("C.pc", instr_pc, 32'(k - 1));
                chk("C.instr", instr, wc[k-1]);
            end
            nxt();
            neg();
            chk("C.wait_addr", imem_addr, 32'(k));
            nxt();
        end
        neg();
        chk("C.no_req4", 32'(imem_req), 32'd0);
        chk("C.hct_pc", instr_pc, 32'd3);
        chk("C.hct_instr", instr, 32'hA000_0000);
        chk("C.not_halted", 32'(halted), 32'd0);
        chk("C.busy", 32'(busy), 32'd0);
        nxt();
        neg();
        chk("C.halted", 32'(halted), 32'd1);
        chk("C.halt_req", 32'(imem_req), 32'd0);
        chk("C.halt_valid", 32'(instr_valid), 32'd0);
        nxt();
        imem_ack = 1'b0;

        // D: flush while waiting on addr 5
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        nxt();
        start = 1'b0;
        imem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            imem_rdata = 32'(k + 1);
            nxt();
            nxt();
        end
        instr_ready = 1'b0; imem_ack = 1'b0;
        neg();
        chk("D.addr5", imem_addr, 32'd5);
        chk("D.pc4", instr_pc, 32'd4);
        nxt();
        flush = 1'b1; flush_pc = 32'h10;
        neg();
        chk("D.flush_req", 32'(imem_req), 32'd1);
        chk("D.flush_valid", 32'(instr_valid), 32'd1);
        nxt();
        flush = 1'b0;
        neg();
        chk("D.drop_valid", 32'(instr_valid), 32'd0);
        chk("D.drop_req", 32'(imem_req), 32'd1);
        chk("D.drop_addr", imem_addr, 32'd5);
        nxt();
        imem_ack = 1'b1; imem_rdata = 32'h0000_DEAD;
        neg();
        chk("D.drop_addr2", imem_addr, 32'd5);
        nxt();
        imem_rdata = 32'h77; instr_ready = 1'b1;
        neg();
        chk("D.drop_discard", 32'(instr_valid), 32'd0);
        chk("D.new_req", 32'(imem_req), 32'd1);
        chk("D.new_addr", imem_addr, 32'h10);
        nxt();
        neg();
        chk("D.wait_addr", imem_addr, 32'h10);
        nxt();
        imem_ack = 1'b0;
        neg();
        chk("D.first_valid", 32'(instr_valid), 32'd1);
        chk("D.first_pc", instr_pc, 32'h10);
        chk("D.first_instr", instr, 32'h77);
        nxt();

        // E: pc wrap via flush from IDLE
        do_reset();
        flush = 1'b1; flush_pc = 32'hFFFF_FFFF;
        nxt();
        flush = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5;
        instr_ready = 1'b1;
        neg();
        chk("E.addr_max", imem_addr, 32'hFFFF_FFFF);
        nxt();
        nxt();
        imem_rdata = 32'h6;
        neg();
        chk("E.pc_max", instr_pc, 32'hFFFF_FFFF);
        chk("E.instr_max", instr, 32'h5);
        chk("E.addr_wrap", imem_addr, 32'd0);
        nxt();
        nxt();
        imem_ack = 1'b0;
        neg();
        chk("E.pc_wrap", instr_pc, 32'd0);
        chk("E.instr_wrap", instr, 32'h6);
        nxt();

        // F: reset mid-WAIT, stray ack afterwards
        neg();
        chk("F.wait_req", 32'(imem_req), 32'd1);
        chk("F.wait_addr", imem_addr, 32'd1);
        nxt();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        neg();
        chk_all_zero("F.post_reset");
        nxt();
        imem_ack = 1'b1; imem_rdata = 32'h99;
        neg();
        chk("F.stray_valid", 32'(instr_valid), 32'd0);
        chk("F.stray_req", 32'(imem_req), 32'd0);
        nxt();
        neg();
        chk("F.stray_valid2", 32'(instr_valid), 32'd0);
        imem_ack = 1'b0;
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
